// File: rtl/imem_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words and writes
// them to instruction memory, holding the core stalled until the load ends.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, word_count begin a load of word_count words
//   byte_in/valid/ready  byte stream handshake (MSB of each word first)
//   mem_we/addr/wd    instruction-memory write port (byte address)
//   core_stall        freezes core PC and pipeline until load complete
//   busy, done, err   status; err flags an oversize word_count (sticky)
module imem_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wd,
  output logic              core_stall,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0] MAXW = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [31:0]       shift_q, shift_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              stall_q, stall_d;
  logic              last_word;

  assign last_word = ({1'b0, widx_q} == (cnt_q - 1'b1));

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    widx_d  = widx_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (word_count > MAXW) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (word_count == '0) begin
            err_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            cnt_d   = word_count;
            widx_d  = '0;
            bcnt_d  = '0;
            state_d = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (byte_valid) begin
          shift_d = {shift_q[23:0], byte_in};
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          widx_d  = widx_q + 1'b1;
          bcnt_d  = '0;
          state_d = S_RECV;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered so the stall releases/reasserts with the state change
    stall_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      widx_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      stall_q <= 1'b1;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      widx_q  <= widx_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign byte_ready = (state_q == S_RECV);
  assign busy       = (state_q == S_RECV) || (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign mem_we     = (state_q == S_WRITE);
  assign mem_wd     = mem_we ? shift_q : 32'h0;
  assign mem_addr   = mem_we ?
    BASE_ADDR + {{(30-ADDR_W){1'b0}}, widx_q, 2'b00} : 32'h0;
  assign core_stall = stall_q;
  assign err        = err_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the pipelined core reads at fetch.
- Receives a program as a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words.
- Issues one word write per word into the instruction-memory write port.
- Holds the core stalled until the programmed word count has been written, then releases it with PC fetch starting at BASE_ADDR.

Parameters:
ADDR_W, 8, word-address width of instruction memory (depth = 2**ADDR_W words)
BASE_ADDR, 32'h00000000, byte address of first loaded word (word aligned)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle pulse, begins a load
word_count  in  ADDR_W+1  number of words to load, sampled on accepted start
byte_in  in  8  program byte, most significant byte of each word first
byte_valid  in  1  byte_in valid
byte_ready  out  1  loader accepts byte this cycle
mem_we  out  1  instruction-memory write enable, one-cycle pulse per word
mem_addr  out  32  byte address of word being written
mem_wd  out  32  word being written
core_stall  out  1  holds core PC and pipeline frozen
busy  out  1  load in progress
done  out  1  load complete, core released
err  out  1  word_count exceeded 2**ADDR_W; sticky until next accepted start or reset

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - Outputs: core_stall=1, all other outputs 0, mem_addr=0, mem_wd=0.
  - Byte counter, word index, shift register and latched count are cleared.
  - Reset mid-load aborts the load immediately. Words already written remain in memory.
- IDLE state:
  - byte_ready=0, core_stall=1.
  - start with word_count > 2**ADDR_W: set err=1, stay in IDLE.
  - start with word_count=0: go to DONE next cycle.
  - start otherwise: latch word_count, clear err, word_idx=0, byte_cnt=0, go to RECV.
- RECV state:
  - byte_ready=1, busy=1.
  - On each byte_valid&byte_ready: shift register <= {shift[23:0], byte_in}, byte_cnt++.
  - On the 4th byte (byte_cnt==3), go to WRITE next cycle.
  - byte_valid low: hold, no timeout.
- WRITE state (exactly 1 cycle):
  - byte_ready=0, mem_we=1, mem_wd=assembled word, mem_addr=BASE_ADDR + 4*word_idx.
  - If word_idx == count-1: go to DONE. Otherwise word_idx++, byte_cnt=0, return to RECV.
  - Write latency: mem_we is asserted the cycle after the 4th byte is accepted.
- DONE state:
  - done=1, busy=0, core_stall=0, byte_ready=0, mem_we=0.
  - start here behaves as in IDLE: core_stall is reasserted the cycle after start, done drops.
- start is ignored in RECV and WRITE.
- Bytes presented while byte_ready=0 are not consumed.
- mem_addr wraps modulo 2**32. The count check makes overflow of the memory range impossible.
- core_stall is a registered output; it changes only in the cycle after a state transition.

Test Plan:
1. Reset then idle: hold rst_n=0 for 2 cycles, release -> core_stall=1, done=0, busy=0, byte_ready=0, mem_we=0 for 10 cycles.
2. Single word load: start with word_count=1, feed bytes 8C,01,00,04 back-to-back -> exactly one mem_we pulse, mem_addr=0x00000000, mem_wd=0x8C010004; done=1 and core_stall=0 on the following cycle.
3. Multi-word with gaps: word_count=3, random byte_valid gaps, words 0x20080005, 0x20090003, 0x01095020 -> writes to addresses 0x0, 0x4, 0x8 in order with those data; no mem_we while byte_valid is idle; exactly 12 bytes consumed.
4. Boundaries:
   - word_count=0 -> done after 1 cycle, no writes.
   - ADDR_W=8 with word_count=257 -> err=1, stays IDLE, core_stall=1.
   - word_count=256 -> last write at mem_addr=0x3FC.
5. Reset mid-load: assert rst_n=0 after 2 of 3 words -> IDLE, core_stall=1, byte_counter cleared; a fresh start loading 1 word writes address 0x0 correctly.
6. Reload and ignored start: from DONE, start with word_count=2 -> core_stall=1 next cycle, 2 writes, done again; a start pulse during RECV has no effect.
